// File: rtl/simplebus_pkg.sv
// -----------------------------------------------------------------------------
// simplebus_pkg
//   Shared definitions for the simplebus memory follower.
//   - follower_state_t : FSM state encoding of the follower
//   - ADDR_PHASES_MIN/MAX : legal range of address phases per transfer
//   - assemble_index() : folds one address byte into a running word index
// -----------------------------------------------------------------------------
package simplebus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_WAIT,
        RD_DATA,
        WR_DATA
    } follower_state_t;

    localparam int ADDR_PHASES_MIN = 2;
    localparam int ADDR_PHASES_MAX = 4;

    // Working width of the index accumulator; wide enough for any legal
    // combination of DATA_W and ADDR_PHASES used with this block.
    localparam int IDX_ACC_W = 64;

    // Shifts the accumulated index up by one byte lane, appends the new lane
    // (MSB-first assembly) and keeps only the low idx_w bits, so address
    // bits above the memory index fall away as they are shifted out.
    function automatic logic [IDX_ACC_W-1:0] assemble_index(
        input logic [IDX_ACC_W-1:0] acc,
        input logic [IDX_ACC_W-1:0] lane,
        input int                   lane_w,
        input int                   idx_w
    );
        logic [IDX_ACC_W-1:0] mask;
        if (idx_w >= IDX_ACC_W) begin
            mask = '1;
        end else begin
            mask = (IDX_ACC_W'(1) << idx_w) - IDX_ACC_W'(1);
        end
        return ((acc << lane_w) | lane) & mask;
    endfunction

endpackage

// File: rtl/simplebus_follower_mem.sv
// -----------------------------------------------------------------------------
// simplebus_follower_mem
//   2**MEM_AW x DATA_W word store for the follower. One synchronous write
//   port and one combinational read port, so a read in the cycle after a
//   write to the same index already returns the new word. Contents are not
//   affected by reset; every word starts at INIT_VAL.
//
// Ports:
//   i_clock   - rising-edge clock
//   i_wr_en   - write strobe
//   i_wr_idx  - write word index
//   i_wr_data - write data
//   i_rd_idx  - read word index
//   o_rd_data - combinational read data
// -----------------------------------------------------------------------------
module simplebus_follower_mem #(
    parameter int DATA_W   = 8,
    parameter int MEM_AW   = 16,
    parameter int INIT_VAL = 0
) (
    input  logic              i_clock,
    input  logic              i_wr_en,
    input  logic [MEM_AW-1:0] i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [MEM_AW-1:0] i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: DATA_W'(INIT_VAL)};

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/simplebus_burst_follower.sv
// -----------------------------------------------------------------------------
// simplebus_burst_follower
//   Memory follower on the shared simplebus. A transfer is ADDR_PHASES
//   address bytes (first one, marked by start, is the device ID; the rest
//   form the word index MSB first) followed by 1 or BURST_LEN data beats.
//
//   Data-valid semantics: there is no ready/back-pressure. A beat moves in
//   exactly the cycle its dataValid is high. On writes the leader owns
//   dv_in and may leave gaps (bounded by TIMEOUT); on reads this follower
//   drives dv_out high on RD_LAT+1.. cycles after the last address phase,
//   one beat per cycle with no gaps.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   start               - first (ID) address phase marker
//   read, burst         - direction and burst flag, taken in last phase
//   address             - address byte lane
//   data_in, dv_in      - resolved bus data / dataValid (write beats)
//   data_out, data_oe   - read data and its drive enable
//   dv_out, dv_oe       - read dataValid and its drive enable
//   err                 - one-cycle pulse when a write beat times out
//   busy                - follower is inside a transfer (state != IDLE)
// -----------------------------------------------------------------------------
module simplebus_burst_follower
    import simplebus_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_PHASES = 3,
    parameter int DEV_ID      = 0,
    parameter int MEM_AW      = 16,
    parameter int RD_LAT      = 2,
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              read,
    input  logic              burst,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dv_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              dv_out,
    output logic              dv_oe,
    output logic              err,
    output logic              busy
);

    localparam int PH_W   = 3;
    localparam int WAIT_W = 4;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    if (ADDR_PHASES < ADDR_PHASES_MIN || ADDR_PHASES > ADDR_PHASES_MAX) begin : g_bad_phases
        $error("simplebus_burst_follower: ADDR_PHASES out of range");
    end

    follower_state_t   r_state;
    follower_state_t   w_next;
    logic [PH_W-1:0]   r_phase;
    logic [MEM_AW-1:0] r_idx;
    logic [BEAT_W-1:0] r_beats;
    logic [WAIT_W-1:0] r_wait;
    logic [TMO_W-1:0]  r_tmo;

    logic                 w_id_hit;
    logic                 w_last_phase;
    logic                 w_last_beat;
    logic                 w_timeout;
    logic [BEAT_W-1:0]    w_beats_init;
    logic [IDX_ACC_W-1:0] w_idx_full;
    logic [MEM_AW-1:0]    w_idx_asm;
    logic                 w_unused_idx_bits;
    logic                 w_mem_we;
    logic [DATA_W-1:0]    w_rd_data;

    assign w_id_hit     = start && (address == DATA_W'(DEV_ID));
    assign w_last_phase = (r_phase == PH_W'(ADDR_PHASES - 1));
    assign w_last_beat  = (r_beats == BEAT_W'(1));
    assign w_timeout    = !dv_in && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_beats_init = burst ? BEAT_W'(BURST_LEN) : BEAT_W'(1);

    // Index is built in place: each ADDR cycle shifts the next byte in and
    // the mask drops bits beyond MEM_AW.
    assign w_idx_full        = assemble_index(IDX_ACC_W'(r_idx), IDX_ACC_W'(address), DATA_W, MEM_AW);
    assign w_idx_asm         = w_idx_full[MEM_AW-1:0];
    assign w_unused_idx_bits = ^w_idx_full;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; bus enables are decoded from the state alone
    // so an asynchronous reset drops them in the same cycle.
    always_comb begin
        w_next   = r_state;
        data_out = '0;
        data_oe  = 1'b0;
        dv_out   = 1'b0;
        dv_oe    = 1'b0;
        err      = 1'b0;
        busy     = (r_state != IDLE);
        w_mem_we = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_id_hit) w_next = ADDR;
            end
            ADDR: begin
                if (w_last_phase) begin
                    if (read) w_next = (RD_LAT == 0) ? RD_DATA : RD_WAIT;
                    else      w_next = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (r_wait == WAIT_W'(RD_LAT - 1)) w_next = RD_DATA;
            end
            RD_DATA: begin
                data_out = w_rd_data;
                data_oe  = 1'b1;
                dv_out   = 1'b1;
                dv_oe    = 1'b1;
                if (w_last_beat) w_next = IDLE;
            end
            WR_DATA: begin
                if (dv_in) begin
                    w_mem_we = 1'b1;
                    if (w_last_beat) w_next = IDLE;
                end else if (w_timeout) begin
                    err    = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Phase, index, beat, latency and timeout counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
            r_idx   <= '0;
            r_beats <= '0;
            r_wait  <= '0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_id_hit) begin
                        r_phase <= PH_W'(1);
                        r_idx   <= '0;
                        r_wait  <= '0;
                        r_tmo   <= '0;
                    end
                end
                ADDR: begin
                    r_idx   <= w_idx_asm;
                    r_phase <= r_phase + PH_W'(1);
                    if (w_last_phase) r_beats <= w_beats_init;
                end
                RD_WAIT: begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
                RD_DATA: begin
                    r_idx   <= r_idx + MEM_AW'(1);
                    r_beats <= r_beats - BEAT_W'(1);
                end
                WR_DATA: begin
                    if (dv_in) begin
                        r_idx   <= r_idx + MEM_AW'(1);
                        r_beats <= r_beats - BEAT_W'(1);
                        r_tmo   <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    simplebus_follower_mem #(
        .DATA_W   (DATA_W),
        .MEM_AW   (MEM_AW),
        .INIT_VAL (DEV_ID)
    ) u_mem (
        .i_clock   (clock),
        .i_wr_en   (w_mem_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (data_in),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_simplebus_burst_follower.sv
// -----------------------------------------------------------------------------
// tb_simplebus_burst_follower
//   Two followers share the same bus inputs: dut_a with RD_LAT=2 and dut_b
//   with RD_LAT=0. Both see identical traffic, so one memory model serves
//   both; only the read-beat timing expected from each differs.
// -----------------------------------------------------------------------------
module tb_simplebus_burst_follower;

    localparam int DATA_W      = 8;
    localparam int ADDR_PHASES = 3;
    localparam int DEV_ID      = 1;
    localparam int MEM_AW      = 16;
    localparam int BURST_LEN   = 4;
    localparam int TIMEOUT     = 15;
    localparam int LAT_A       = 2;
    localparam int LAT_B       = 0;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic              start, read, burst, dv_in;
    logic [DATA_W-1:0] address, data_in;

    logic [DATA_W-1:0] a_data_out, b_data_out;
    logic a_data_oe, a_dv_out, a_dv_oe, a_err, a_busy;
    logic b_data_oe, b_dv_out, b_dv_oe, b_err, b_busy;

    simplebus_burst_follower #(
        .DATA_W(DATA_W), .ADDR_PHASES(ADDR_PHASES), .DEV_ID(DEV_ID), .MEM_AW(MEM_AW),
        .RD_LAT(LAT_A), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start), .read(read), .burst(burst),
        .address(address), .data_in(data_in), .dv_in(dv_in),
        .data_out(a_data_out), .data_oe(a_data_oe), .dv_out(a_dv_out), .dv_oe(a_dv_oe),
        .err(a_err), .busy(a_busy)
    );

    simplebus_burst_follower #(
        .DATA_W(DATA_W), .ADDR_PHASES(ADDR_PHASES), .DEV_ID(DEV_ID), .MEM_AW(MEM_AW),
        .RD_LAT(LAT_B), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start), .read(read), .burst(burst),
        .address(address), .data_in(data_in), .dv_in(dv_in),
        .data_out(b_data_out), .data_oe(b_data_oe), .dv_out(b_dv_out), .dv_oe(b_dv_oe),
        .err(b_err), .busy(b_busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [int];

    function automatic logic [7:0] model_rd(input int idx);
        int i;
        i = idx % 65536;
        return model_mem.exists(i) ? model_mem[i] : 8'(DEV_ID);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        start   = 1'b0;
        read    = 1'b0;
        burst   = 1'b0;
        address = '0;
        dv_in   = 1'b0;
        data_in = '0;
    endtask

    task automatic send_addr(input logic [7:0] id, input int idx, input bit rd, input bit bst, input bit match);
        logic [15:0] a16;
        a16 = 16'(idx);
        next_cycle();
        drive_idle();
        start   = 1'b1;
        address = id;
        @(negedge clock);
        check_eq("a_busy_ph0", a_busy, 0);
        next_cycle();
        start   = 1'b0;
        address = a16[15:8];
        @(negedge clock);
        check_eq("a_busy_ph1", a_busy, match);
        check_eq("b_busy_ph1", b_busy, match);
        next_cycle();
        address = a16[7:0];
        read    = rd;
        burst   = bst;
        @(negedge clock);
        check_eq("a_busy_ph2", a_busy, match);
        check_eq("b_busy_ph2", b_busy, match);
    endtask

    task automatic chk_write_cycle(input bit match);
        check_eq("a_wr_data_oe", a_data_oe, 0);
        check_eq("a_wr_dv_oe", a_dv_oe, 0);
        check_eq("a_wr_err", a_err, 0);
        check_eq("a_wr_busy", a_busy, match);
        check_eq("b_wr_data_oe", b_data_oe, 0);
        check_eq("b_wr_dv_oe", b_dv_oe, 0);
        check_eq("b_wr_busy", b_busy, match);
    endtask

    task automatic do_write(input logic [7:0] id, input int idx, input bit bst, input logic [31:0] data);
        bit match;
        int beats;
        int ngap;
        match = (id == 8'(DEV_ID));
        beats = bst ? BURST_LEN : 1;
        send_addr(id, idx, 1'b0, bst, match);
        for (int i = 0; i < beats; i++) begin
            ngap = $urandom_range(0, 2);
            for (int g = 0; g < ngap; g++) begin
                next_cycle();
                drive_idle();
                @(negedge clock);
                chk_write_cycle(match);
            end
            next_cycle();
            drive_idle();
            dv_in   = 1'b1;
            data_in = data[8*i +: 8];
            if (match) model_mem[(idx + i) % 65536] = data[8*i +: 8];
            @(negedge clock);
            chk_write_cycle(match);
        end
        next_cycle();
        drive_idle();
        @(negedge clock);
        check_eq("a_wr_done_busy", a_busy, 0);
        check_eq("b_wr_done_busy", b_busy, 0);
    endtask

    task automatic do_read(input logic [7:0] id, input int idx, input bit bst);
        bit match;
        int beats;
        bit act_a, act_b;
        logic [7:0] exp_a, exp_b;
        match = (id == 8'(DEV_ID));
        beats = bst ? BURST_LEN : 1;
        send_addr(id, idx, 1'b1, bst, match);
        for (int k = 1; k <= LAT_A + 1 + beats; k++) begin
            next_cycle();
            drive_idle();
            @(negedge clock);
            act_a = match && (k >= LAT_A + 1) && (k < LAT_A + 1 + beats);
            act_b = match && (k >= LAT_B + 1) && (k < LAT_B + 1 + beats);
            exp_a = act_a ? model_rd(idx + k - (LAT_A + 1)) : 8'h00;
            exp_b = act_b ? model_rd(idx + k - (LAT_B + 1)) : 8'h00;
            check_eq("a_rd_dv_out", a_dv_out, act_a);
            check_eq("a_rd_dv_oe", a_dv_oe, act_a);
            check_eq("a_rd_data_oe", a_data_oe, act_a);
            check_eq("a_rd_data", a_data_out, exp_a);
            check_eq("a_rd_busy", a_busy, match && (k < LAT_A + 1 + beats));
            check_eq("b_rd_dv_out", b_dv_out, act_b);
            check_eq("b_rd_dv_oe", b_dv_oe, act_b);
            check_eq("b_rd_data_oe", b_data_oe, act_b);
            check_eq("b_rd_data", b_data_out, exp_b);
            check_eq("b_rd_busy", b_busy, match && (k < LAT_B + 1 + beats));
        end
    endtask

    task automatic do_timeout(input int idx);
        send_addr(8'(DEV_ID), idx, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            next_cycle();
            drive_idle();
            @(negedge clock);
            check_eq("a_tmo_err", a_err, (k == TIMEOUT));
            check_eq("a_tmo_busy", a_busy, (k <= TIMEOUT));
            check_eq("a_tmo_data_oe", a_data_oe, 0);
            check_eq("b_tmo_err", b_err, (k == TIMEOUT));
            check_eq("b_tmo_busy", b_busy, (k <= TIMEOUT));
        end
    endtask

    task automatic reset_mid_burst(input int idx);
        send_addr(8'(DEV_ID), idx, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= LAT_A + 1; k++) begin
            next_cycle();
            drive_idle();
        end
        @(negedge clock);
        check_eq("a_rst_beat1_dv", a_dv_out, 1);
        check_eq("a_rst_beat1_data", a_data_out, model_rd(idx));
        next_cycle();
        #1;
        check_eq("a_rst_beat2_oe", a_data_oe, 1);
        check_eq("a_rst_beat2_data", a_data_out, model_rd(idx + 1));
        reset = 1'b1;
        #1;
        check_eq("a_rst_data_oe", a_data_oe, 0);
        check_eq("a_rst_dv_oe", a_dv_oe, 0);
        check_eq("a_rst_dv_out", a_dv_out, 0);
        check_eq("a_rst_data_out", a_data_out, 0);
        check_eq("a_rst_busy", a_busy, 0);
        check_eq("b_rst_busy", b_busy, 0);
        check_eq("b_rst_data_oe", b_data_oe, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("a_post_rst_busy", a_busy, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  r_id;
        int          r_idx;
        bit          r_bst;
        logic [31:0] r_data;

        reset = 1'b1;
        drive_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("a_reset_data_out", a_data_out, 0);
        check_eq("a_reset_data_oe", a_data_oe, 0);
        check_eq("a_reset_dv_out", a_dv_out, 0);
        check_eq("a_reset_dv_oe", a_dv_oe, 0);
        check_eq("a_reset_err", a_err, 0);
        check_eq("a_reset_busy", a_busy, 0);
        check_eq("b_reset_busy", b_busy, 0);
        check_eq("b_reset_data_oe", b_data_oe, 0);
        next_cycle();
        reset = 1'b0;

        // single write then read back
        do_write(8'h01, 'h0406, 1'b0, 32'h0000_00DC);
        do_read (8'h01, 'h0406, 1'b0);

        // burst across the top of the index space
        do_write(8'h01, 'hFFFE, 1'b1, 32'h4433_2211);
        do_read (8'h01, 'hFFFE, 1'b1);
        do_read (8'h01, 'h0000, 1'b0);

        // foreign device ID is ignored entirely
        do_write(8'h02, 'h0407, 1'b0, 32'h0000_005A);
        do_read (8'h02, 'h0407, 1'b0);
        do_read (8'h01, 'h0407, 1'b0);

        // write-data timeout leaves memory untouched
        do_timeout('h0010);
        do_read(8'h01, 'h0010, 1'b0);

        // asynchronous reset in the middle of a burst read
        reset_mid_burst('h0020);
        do_write(8'h01, 'h0020, 1'b0, 32'h0000_0077);
        do_read (8'h01, 'h0020, 1'b1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            r_id  = ($urandom_range(0, 5) == 0) ? 8'h02 : 8'h01;
            r_bst = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       r_idx = $urandom_range(0, 63);
                1:       r_idx = 'hFFFC + $urandom_range(0, 3);
                default: r_idx = $urandom_range(0, 65535);
            endcase
            r_data = $urandom;
            if ($urandom_range(0, 1) == 1) do_write(r_id, r_idx, r_bst, r_data);
            else                           do_read (r_id, r_idx, r_bst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
